// File: rtl/rbcp_axi_pkg.sv
// Shared types and helpers for the RBCP <-> AXI4-Lite bridge masters.
package rbcp_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_ACK  = 2'd3
  } rd_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [1:0]  lane;
  } rd_req_t;

  // Big-endian lane is 3-a, which for two bits is the bitwise inverse.
  function automatic logic [1:0] lane_of(input logic [1:0] a, input bit big_endian);
    return big_endian ? ~a : a;
  endfunction

  function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rbcp_axi_rd_master_if.sv
// AXI4-Lite read channels (AR + R) between the RBCP front end and the read adapter.
interface rbcp_axi_rd_master_if;
  import rbcp_axi_pkg::*;

  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rbcp_word_cache.sv
// One-word read cache: tag/data/valid, hit compare and invalidation.
module rbcp_word_cache
  import rbcp_axi_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] lookup_tag,
  input  logic        wr_en,
  input  logic        sess_end,
  input  logic        drop,
  input  logic        fill,
  input  logic [29:0] fill_tag,
  input  logic [31:0] fill_data,
  output logic        hit,
  output logic [31:0] data
);

  logic        valid;
  logic [29:0] tag;
  logic        tag_match;

  assign tag_match = (tag == lookup_tag);
  // A same-cycle write or session end invalidates before the lookup is honoured.
  assign hit = CACHE_EN && valid && tag_match && !wr_en && !sess_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end else if (drop || sess_end || (wr_en && tag_match)) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rbcp_axi_rd_master.sv
// RBCP byte reads -> single-outstanding AXI4-Lite word reads, with a one-word cache.
module rbcp_axi_rd_master
  import rbcp_axi_pkg::*;
#(
  parameter bit BIG_ENDIAN     = 1'b0,
  parameter bit CACHE_EN       = 1'b1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rbcp_act,
  input  logic [31:0]          rbcp_addr,
  input  logic                 rbcp_re,
  input  logic                 rbcp_we,
  output logic [7:0]           rbcp_rd,
  output logic                 rbcp_ack,
  rbcp_axi_rd_master_if.master m_axi,
  output logic                 err_flag,
  output logic                 timeout_flag,
  input  logic                 flag_clr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  rd_state_e     state, state_nx;
  rd_req_t       req_q;
  logic [7:0]    rd_q;
  logic          act_q, nocache_q;
  logic [TW-1:0] tmo_cnt;

  logic          act_fall, in_flight, wr_inflight, r_hs, rsp_ok;
  logic          cache_hit, fill, drop, rd_miss, tmo_set;
  logic [31:0]   cache_data;
  logic [1:0]    lane_now;

  assign act_fall    = act_q && !rbcp_act;
  assign in_flight   = (state == ST_AR) || (state == ST_R);
  assign wr_inflight = in_flight && rbcp_we && (rbcp_addr[31:2] == req_q.word_addr);
  assign r_hs        = (state == ST_R) && m_axi.rvalid;
  assign rsp_ok      = (m_axi.rresp == AXI_RESP_OKAY);
  assign lane_now    = lane_of(rbcp_addr[1:0], BIG_ENDIAN);
  assign rd_miss     = (state == ST_IDLE) && rbcp_re && !cache_hit;
  // Anything that touched the in-flight word makes its data uncacheable.
  assign fill        = r_hs && rsp_ok && !nocache_q && !wr_inflight && !act_fall;
  assign drop        = r_hs && !rsp_ok;
  assign tmo_set     = in_flight && (state_nx == state) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  rbcp_word_cache #(.CACHE_EN(CACHE_EN)) u_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_tag (rbcp_addr[31:2]),
    .wr_en      (rbcp_we),
    .sess_end   (act_fall),
    .drop       (drop),
    .fill       (fill),
    .fill_tag   (req_q.word_addr),
    .fill_data  (m_axi.rdata),
    .hit        (cache_hit),
    .data       (cache_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (rbcp_re) state_nx = cache_hit ? ST_ACK : ST_AR;
      ST_AR:   if (m_axi.arready) state_nx = ST_R;
      ST_R:    if (m_axi.rvalid) state_nx = ST_ACK;
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axi.arvalid = (state == ST_AR);
    m_axi.rready  = (state == ST_R);
    rbcp_ack      = (state == ST_ACK);
  end

  assign m_axi.araddr = {req_q.word_addr, 2'b00};
  assign m_axi.arprot = ARPROT_DEFAULT;
  assign rbcp_rd      = rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q        <= '0;
      rd_q         <= '0;
      act_q        <= 1'b0;
      nocache_q    <= 1'b0;
      tmo_cnt      <= '0;
      err_flag     <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      act_q <= rbcp_act;
      if (rd_miss) begin
        req_q     <= '{word_addr: rbcp_addr[31:2], lane: lane_now};
        nocache_q <= 1'b0;
      end else if (wr_inflight || (in_flight && act_fall)) begin
        nocache_q <= 1'b1;
      end
      if ((state == ST_IDLE) && rbcp_re && cache_hit)
        rd_q <= lane_sel(cache_data, lane_now);
      else if (r_hs)
        rd_q <= rsp_ok ? lane_sel(m_axi.rdata, req_q.lane) : 8'h00;
      // Timeout only reports; the AXI transaction keeps waiting.
      if (state_nx != state)
        tmo_cnt <= '0;
      else if (in_flight && (tmo_cnt != TW'(TIMEOUT_CYCLES)))
        tmo_cnt <= tmo_cnt + 1'b1;
      err_flag     <= drop    || (err_flag && !flag_clr);
      timeout_flag <= tmo_set || (timeout_flag && !flag_clr);
    end
  end

endmodule

// File: tb/tb_rbcp_axi_rd_master.sv
// Bench: LE/1024 and BE/16 instances in lockstep against a word-cache reference model.
module tb_rbcp_axi_rd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        act = 1'b0, re = 1'b0, we = 1'b0, flag_clr = 1'b0;
  logic [31:0] addr = '0;
  logic        arready = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic [7:0]  rd0, rd1;
  logic        ack0, ack1, err0, err1, tmo0, tmo1;

  int n_checks = 0;
  int n_errors = 0;
  int ar_cnt   = 0;
  logic arv_prev = 1'b0;

  // reference model: one cached word plus sticky error
  bit          m_valid = 0;
  logic [29:0] m_tag = '0;
  logic [31:0] m_word = '0;
  bit          m_err = 0;

  typedef struct {
    int          lat;
    int          n_ar;
    logic [31:0] araddr;
    bit          stable;
    bit          once;
    logic [7:0]  rd0;
    logic [7:0]  rd1;
  } obs_t;

  typedef struct {
    bit         hit;
    logic [7:0] rd0;
    logic [7:0] rd1;
  } exp_t;

  rbcp_axi_rd_master_if ax0 ();
  rbcp_axi_rd_master_if ax1 ();

  assign ax0.arready = arready;
  assign ax0.rvalid  = rvalid;
  assign ax0.rdata   = rdata;
  assign ax0.rresp   = rresp;
  assign ax1.arready = arready;
  assign ax1.rvalid  = rvalid;
  assign ax1.rdata   = rdata;
  assign ax1.rresp   = rresp;

  rbcp_axi_rd_master #(.BIG_ENDIAN(1'b0), .CACHE_EN(1'b1), .TIMEOUT_CYCLES(1024)) dut0 (
    .clk(clk), .rst_n(rst_n), .rbcp_act(act), .rbcp_addr(addr), .rbcp_re(re), .rbcp_we(we),
    .rbcp_rd(rd0), .rbcp_ack(ack0), .m_axi(ax0), .err_flag(err0), .timeout_flag(tmo0),
    .flag_clr(flag_clr));

  rbcp_axi_rd_master #(.BIG_ENDIAN(1'b1), .CACHE_EN(1'b1), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .rbcp_act(act), .rbcp_addr(addr), .rbcp_re(re), .rbcp_we(we),
    .rbcp_rd(rd1), .rbcp_ack(ack1), .m_axi(ax1), .err_flag(err1), .timeout_flag(tmo1),
    .flag_clr(flag_clr));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ax0.arvalid && !arv_prev) ar_cnt++;
    arv_prev = ax0.arvalid;
  end

  task automatic do_read(input logic [31:0] a, input logic [31:0] data, input logic [1:0] resp,
                         input int ar_dly, input int r_dly, input bit with_we, output obs_t o);
    int phase, w, start;
    o.lat = -1; o.araddr = '0; o.stable = 1; o.once = 0; o.rd0 = '0; o.rd1 = '0;
    phase = 0; w = 0; start = ar_cnt;
    @(negedge clk); addr = a; re = 1; we = with_we;
    @(negedge clk); re = 0; we = 0;
    for (int cyc = 1; cyc < ar_dly + r_dly + 20; cyc++) begin
      if (ack0) begin o.lat = cyc; o.rd0 = rd0; o.rd1 = rd1; break; end
      if (phase == 0 && ax0.arvalid) begin o.araddr = ax0.araddr; phase = 1; w = 0; end
      if (phase == 1) begin
        if (!ax0.arvalid || ax0.araddr !== o.araddr) o.stable = 0;
        if (w == ar_dly) begin arready = 1; phase = 2; end else w++;
      end else if (phase == 2) begin
        arready = 0; w = 0; phase = 3;
      end
      if (phase == 3) begin
        if (w == r_dly) begin rvalid = 1; rdata = data; rresp = resp; phase = 4; end else w++;
      end
      @(negedge clk);
    end
    arready = 0; rvalid = 0;
    @(negedge clk);
    o.once = (o.lat > 0) && !ack0;
    o.n_ar = ar_cnt - start;
  endtask

  // Reference prediction, then the bus transaction.
  task automatic xact(input logic [31:0] a, input logic [31:0] data, input logic [1:0] resp,
                      input int ar_dly, input int r_dly, input bit with_we,
                      output obs_t o, output exp_t e);
    logic [31:0] word;
    bit ok;
    if (with_we && m_tag == a[31:2]) m_valid = 0;
    e.hit = m_valid && (m_tag == a[31:2]);
    word  = e.hit ? m_word : data;
    ok    = e.hit || (resp == 2'b00);
    e.rd0 = ok ? 8'(word >> (8 * a[1:0])) : 8'h00;
    e.rd1 = ok ? 8'(word >> (8 * (3 - a[1:0]))) : 8'h00;
    if (!e.hit) begin
      if (resp == 2'b00) begin m_valid = 1; m_tag = a[31:2]; m_word = data; end
      else begin m_valid = 0; m_err = 1; end
    end
    do_read(a, data, resp, ar_dly, r_dly, with_we, o);
  endtask

  task automatic do_write(input logic [31:0] a);
    @(negedge clk); addr = a; we = 1;
    @(negedge clk); we = 0;
    if (m_tag == a[31:2]) m_valid = 0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); flag_clr = 1;
    @(negedge clk); flag_clr = 0;
    m_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; act = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ax0.arvalid, ax0.rready, ack0, err0, tmo0, ax1.arvalid, ack1} !== 7'b0) begin
      n_errors++; $display("FAIL reset_ctrl: got %b exp 0",
        {ax0.arvalid, ax0.rready, ack0, err0, tmo0, ax1.arvalid, ack1});
    end
    rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (ax0.araddr !== 32'h0 || rd0 !== 8'h0 || ax0.arprot !== 3'b000) begin
      n_errors++; $display("FAIL reset_data: araddr %h rd %h arprot %b exp 0",
        ax0.araddr, rd0, ax0.arprot);
    end
    n_checks++;
    if (rd1 !== 8'h0 || tmo1 !== 1'b0 || err1 !== 1'b0) begin
      n_errors++; $display("FAIL reset_be: rd %h tmo %b err %b exp 0", rd1, tmo1, err1);
    end
  endtask

  task automatic test_miss_then_hits();
    obs_t o; exp_t e;
    logic [7:0] want [4];
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33; want[3] = 8'h44;
    xact(32'h1000, 32'h44332211, 2'b00, 0, 0, 0, o, e);
    n_checks++;
    if (o.n_ar !== 1 || o.araddr !== 32'h1000) begin
      n_errors++; $display("FAIL miss_ar: n_ar %0d addr %h exp 1 00001000", o.n_ar, o.araddr);
    end
    n_checks++;
    if (o.rd0 !== 8'h11 || o.rd1 !== 8'h44 || !o.once) begin
      n_errors++; $display("FAIL miss_rd: le %h be %h once %0d exp 11 44 1", o.rd0, o.rd1, o.once);
    end
    for (int i = 1; i < 4; i++) begin
      xact(32'h1000 + i, 32'hDEADBEEF, 2'b00, 0, 0, 0, o, e);
      n_checks++;
      if (o.lat !== 1 || o.n_ar !== 0) begin
        n_errors++; $display("FAIL hit_lat%0d: lat %0d n_ar %0d exp 1 0", i, o.lat, o.n_ar);
      end
      n_checks++;
      if (o.rd0 !== want[i] || o.rd1 !== want[3-i]) begin
        n_errors++; $display("FAIL hit_rd%0d: le %h be %h exp %h %h", i, o.rd0, o.rd1,
          want[i], want[3-i]);
      end
    end
  endtask

  task automatic test_big_endian();
    obs_t o; exp_t e;
    logic [31:0] d;
    d = $urandom;
    xact(32'h2003, d, 2'b00, 1, 1, 0, o, e);
    n_checks++;
    if (o.n_ar !== 1 || o.araddr !== 32'h2000) begin
      n_errors++; $display("FAIL be_ar: n_ar %0d addr %h exp 1 00002000", o.n_ar, o.araddr);
    end
    n_checks++;
    if (o.rd1 !== d[7:0] || o.rd0 !== d[31:24]) begin
      n_errors++; $display("FAIL be_lane: be %h le %h exp %h %h", o.rd1, o.rd0, d[7:0], d[31:24]);
    end
  endtask

  task automatic test_backpressure();
    obs_t o; exp_t e;
    logic [31:0] a;
    a = 32'h4000 | 32'($urandom_range(0, 3));
    xact(a, $urandom, 2'b00, 10, 5, 0, o, e);
    n_checks++;
    if (!o.stable || o.n_ar !== 1 || o.araddr !== 32'h4000) begin
      n_errors++; $display("FAIL bp_ar: stable %0d n_ar %0d addr %h exp 1 1 00004000",
        o.stable, o.n_ar, o.araddr);
    end
    n_checks++;
    if (!o.once || o.rd0 !== e.rd0 || o.rd1 !== e.rd1) begin
      n_errors++; $display("FAIL bp_rd: once %0d le %h be %h exp 1 %h %h", o.once, o.rd0, o.rd1,
        e.rd0, e.rd1);
    end
    n_checks++;
    if (tmo0 !== 1'b0 || tmo1 !== 1'b0) begin
      n_errors++; $display("FAIL bp_tmo: tmo %b %b exp 0 0", tmo0, tmo1);
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    // each phase shorter than 16 cycles, total longer: counter must restart per state
    xact(32'h5004, $urandom, 2'b00, 12, 12, 0, o, e);
    n_checks++;
    if (tmo1 !== 1'b0) begin
      n_errors++; $display("FAIL tmo_split: got %b exp 0", tmo1);
    end
    xact(32'h5000, $urandom, 2'b00, 40, 0, 0, o, e);
    n_checks++;
    if (tmo1 !== 1'b1 || tmo0 !== 1'b0) begin
      n_errors++; $display("FAIL tmo_set: be %b le %b exp 1 0", tmo1, tmo0);
    end
    n_checks++;
    if (o.n_ar !== 1 || !o.stable || o.rd0 !== e.rd0 || o.rd1 !== e.rd1) begin
      n_errors++; $display("FAIL tmo_data: n_ar %0d stable %0d le %h be %h exp 1 1 %h %h",
        o.n_ar, o.stable, o.rd0, o.rd1, e.rd0, e.rd1);
    end
    pulse_clr();
    n_checks++;
    if (tmo1 !== 1'b0) begin
      n_errors++; $display("FAIL tmo_clr: got %b exp 0", tmo1);
    end
  endtask

  task automatic test_error();
    obs_t o; exp_t e;
    xact(32'h3001, 32'hA5A5A5A5, 2'b10, 0, 2, 0, o, e);
    n_checks++;
    if (o.rd0 !== 8'h00 || o.rd1 !== 8'h00 || err0 !== 1'b1 || err1 !== 1'b1) begin
      n_errors++; $display("FAIL err_rd: le %h be %h err %b %b exp 00 00 1 1", o.rd0, o.rd1,
        err0, err1);
    end
    xact(32'h3001, 32'h12345678, 2'b00, 0, 0, 0, o, e);
    n_checks++;
    if (o.n_ar !== 1 || o.rd0 !== 8'h56) begin
      n_errors++; $display("FAIL err_reread: n_ar %0d rd %h exp 1 56", o.n_ar, o.rd0);
    end
    pulse_clr();
    n_checks++;
    if (err0 !== 1'b0) begin
      n_errors++; $display("FAIL err_clr: got %b exp 0", err0);
    end
  endtask

  task automatic test_invalidate();
    obs_t o; exp_t e;
    xact(32'h1000, $urandom, 2'b00, 0, 0, 0, o, e);
    xact(32'h1001, 32'h0, 2'b00, 0, 0, 0, o, e);
    n_checks++;
    if (o.n_ar !== 0) begin
      n_errors++; $display("FAIL inv_prime: n_ar %0d exp 0", o.n_ar);
    end
    do_write(32'h1002);
    xact(32'h1000, $urandom, 2'b00, 0, 0, 0, o, e);
    n_checks++;
    if (o.n_ar !== 1 || o.rd0 !== e.rd0) begin
      n_errors++; $display("FAIL inv_write: n_ar %0d rd %h exp 1 %h", o.n_ar, o.rd0, e.rd0);
    end
    @(negedge clk); act = 0;
    @(negedge clk); act = 1;
    m_valid = 0;
    xact(32'h1003, $urandom, 2'b00, 0, 0, 0, o, e);
    n_checks++;
    if (o.n_ar !== 1 || o.rd1 !== e.rd1) begin
      n_errors++; $display("FAIL inv_act: n_ar %0d rd %h exp 1 %h", o.n_ar, o.rd1, e.rd1);
    end
    // write and read strobed together on a cached word: read must miss
    xact(32'h1002, $urandom, 2'b00, 0, 0, 1, o, e);
    n_checks++;
    if (o.n_ar !== 1 || o.rd0 !== e.rd0) begin
      n_errors++; $display("FAIL inv_we_re: n_ar %0d rd %h exp 1 %h", o.n_ar, o.rd0, e.rd0);
    end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = 32'h1000 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) do_write(32'h1000 + 32'($urandom_range(0, 15)));
      xact(a, $urandom, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0, o, e);
      n_checks++;
      if (o.n_ar !== (e.hit ? 0 : 1) || (e.hit && o.lat !== 1)) begin
        n_errors++; $display("FAIL rnd_hit%0d: addr %h n_ar %0d lat %0d exp_hit %0d",
          i, a, o.n_ar, o.lat, e.hit);
      end
      n_checks++;
      if (o.rd0 !== e.rd0 || o.rd1 !== e.rd1 || !o.once) begin
        n_errors++; $display("FAIL rnd_rd%0d: addr %h le %h be %h once %0d exp %h %h 1",
          i, a, o.rd0, o.rd1, o.once, e.rd0, e.rd1);
      end
    end
    n_checks++;
    if (err0 !== 1'(m_err)) begin
      n_errors++; $display("FAIL rnd_err: got %b exp %b", err0, m_err);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e;
    bit seen;
    xact(32'h6000, 32'h7766_55AA, 2'b00, 0, 0, 0, o, e);
    @(negedge clk); addr = 32'h6004; re = 1;
    @(negedge clk); re = 0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (ax0.arvalid) seen = 1; else @(negedge clk);
    end
    arready = 1;
    @(negedge clk); arready = 0;
    n_checks++;
    if (!seen || ax0.rready !== 1'b1) begin
      n_errors++; $display("FAIL mid_setup: arvalid_seen %0d rready %b exp 1 1", seen, ax0.rready);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({ax0.arvalid, ax0.rready, ack0} !== 3'b0 || rd0 !== 8'h0 || ax0.araddr !== 32'h0) begin
      n_errors++; $display("FAIL mid_reset: ctl %b rd %h araddr %h exp 0",
        {ax0.arvalid, ax0.rready, ack0}, rd0, ax0.araddr);
    end
    @(negedge clk); rst_n = 1;
    m_valid = 0; m_tag = '0; m_err = 0;
    xact(32'h6000, 32'h0102_0304, 2'b00, 0, 0, 0, o, e);
    n_checks++;
    if (o.n_ar !== 1 || o.araddr !== 32'h6000 || o.rd0 !== 8'h04) begin
      n_errors++; $display("FAIL mid_reread: n_ar %0d addr %h rd %h exp 1 00006000 04",
        o.n_ar, o.araddr, o.rd0);
    end
  endtask

  initial begin
    test_reset();
    test_miss_then_hits();
    test_big_endian();
    test_backpressure();
    test_timeout();
    test_error();
    test_invalidate();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rbcp_axi_rd_master.md
Name: rbcp_axi_rd_master

Overview:
- Upstream front end of the SiTCP register path. Turns byte-wide RBCP read requests into 32-bit AXI4-Lite read transactions on the slave port of the 8-to-32 read adapter.
- Returns the addressed byte to SiTCP with a single-cycle ack.
- Holds a one-word read cache so sequential byte reads within the same 32-bit word issue only one AXI transaction.

Parameters:
- BIG_ENDIAN, 0, byte-lane order: 0 selects lane addr[1:0]; 1 selects lane 3-addr[1:0].
- CACHE_EN, 1, 1 enables the one-word cache; 0 makes every read a miss.
- TIMEOUT_CYCLES, 1024, cycles without AXI progress before timeout_flag sets (width = clog2(TIMEOUT_CYCLES)+1).

Ports:
- clk  in  1  single system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- rbcp_act  in  1  SiTCP RBCP session active.
- rbcp_addr  in  32  RBCP byte address.
- rbcp_re  in  1  read strobe, one-cycle pulse.
- rbcp_we  in  1  write strobe, used only for cache invalidation.
- rbcp_rd  out  8  read byte, valid while rbcp_ack is high.
- rbcp_ack  out  1  one-cycle read acknowledge.
- m_axi_araddr  out  32  word-aligned read address.
- m_axi_arprot  out  3  constant 3'b000.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- err_flag  out  1  sticky; set on any rresp != 2'b00.
- timeout_flag  out  1  sticky; set on timeout.
- flag_clr  in  1  clears err_flag and timeout_flag.

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE; cache_valid=0; tag=0; data=0; timeout counter=0; all outputs 0 (arvalid, rready, ack, rd, araddr, err_flag, timeout_flag).
- FSM states: IDLE, AR, R, ACK.
- IDLE:
  - rbcp_re sampled high with a cache hit (CACHE_EN && cache_valid && tag == rbcp_addr[31:2]): go to ACK, load rbcp_rd from the cached word. Latency from re to ack is 1 cycle.
  - Otherwise (miss): register araddr={rbcp_addr[31:2],2'b00} and the lane; go to AR with arvalid=1 on the next cycle.
- AR:
  - Hold arvalid and araddr stable until arvalid && arready.
  - On that handshake: arvalid=0, rready=1, go to R.
- R:
  - On rvalid && rready: rready=0; capture the selected lane into rbcp_rd; go to ACK.
  - rresp==OKAY: cache_valid=1, tag=araddr[31:2], cache data=rdata.
  - rresp!=OKAY: rbcp_rd=8'h00, cache_valid=0, err_flag=1.
- ACK: rbcp_ack=1 for exactly one cycle, then IDLE. rbcp_rd holds its value until the next ack.
- rbcp_re while not in IDLE: ignored; no queuing.
- Lane select: little-endian returns rdata[8*a+:8] with a=addr[1:0]; BIG_ENDIAN=1 uses a=3-addr[1:0].
- Cache invalidation:
  - rbcp_we with addr[31:2]==tag clears cache_valid.
  - A falling edge of rbcp_act clears cache_valid.
  - If rbcp_we and rbcp_re are high in the same cycle, invalidation takes effect first, so the read is treated as a miss.
  - A write to the word currently in flight marks the result non-cacheable. Data is still returned.
- Timeout:
  - Counter runs in AR and R and resets on each state change.
  - Reaching TIMEOUT_CYCLES sets timeout_flag.
  - The AXI transaction is never abandoned: arvalid and rready stay asserted.
- flag_clr clears both flags. A set event in the same cycle wins.
- The block never issues more than one outstanding AXI read.

Decomposition:
- Shared package rbcp_axi_pkg holds:
  - FSM state typedef (IDLE/AR/R/ACK).
  - AXI_RESP_OKAY=2'b00 and ARPROT_DEFAULT=3'b000.
  - Byte-lane select function, reused by the write-side master.
- One natural sub-module, rbcp_word_cache: holds tag, data and valid, plus the hit compare and the invalidate logic.

Test Plan:
1. Miss then hits: read 0x1000 returning rdata 0x44332211. Expect one AR at 0x1000 and rd=0x11. Then reads 0x1001, 0x1002, 0x1003 give rd=0x22, 0x33, 0x44, each acked 1 cycle after re, with no further arvalid.
2. BIG_ENDIAN=1, same data, read 0x1000 -> rd=0x44. Read 0x2003 -> new AR at 0x2000, lane 0 returned.
3. Backpressure: arready held low 10 cycles, rvalid delayed 5. Expect arvalid and araddr stable throughout, ack exactly once, and no timeout with TIMEOUT_CYCLES=1024.
4. Error: rresp=2'b10 -> rd=0x00 and err_flag=1. A re-read of the same address issues a new AR (not cached). flag_clr clears err_flag.
5. Invalidation: cache 0x1000; rbcp_we to 0x1002 -> next read 0x1000 issues AR. Dropping rbcp_act likewise forces a miss.
6. Reset mid-transaction: assert rst_n low while in R -> outputs go 0 immediately, and the next read is a miss with a fresh AR.
